iq_lpf_decim: RTL and testbench

- Baseband low-pass and decimation stage, directly downstream of the IQ demodulator (demod).
- Consumes the demodulator's I_BB/Q_BB samples, qualified by its demod_rdy strobe.
- Applies a power-of-two-length moving-average (boxcar) filter per channel, decimates by DECIM and emits registered 5-bit I/Q with a one-cycle lpf_rdy strobe toward the chip-correlation stage.

---
 rtl/iq_lpf_decim.sv | 169 ++++++++++++++++
 tb/tb_iq_lpf_decim.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/iq_lpf_decim.sv
// ---------------------------------------------------------------------------
// iq_lpf_decim
//
// Baseband low-pass + decimation stage that sits after the IQ demodulator.
// Each channel (I and Q) runs a LEN = 2**LOG2_LEN tap moving-average filter
// built from a circular delay line and a running sum. The two channels share
// one write pointer, fill counter and decimation counter, so they always
// advance in lockstep. Once the delay line holds LEN real samples, every
// DECIM-th accepted sample produces a rounded, clamped output, registered
// one cycle after the accepting strobe.
//
// Ports:
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   I_BB       in   signed baseband I sample from the demodulator
//   Q_BB       in   signed baseband Q sample from the demodulator
//   demod_rdy  in   one-cycle strobe qualifying I_BB/Q_BB
//   I_LP       out  signed filtered/decimated I, registered, held between strobes
//   Q_LP       out  signed filtered/decimated Q, registered, held between strobes
//   lpf_rdy    out  one-cycle strobe marking an update of I_LP/Q_LP
//
// LOG2_LEN must be >= 1 (the write pointer is LOG2_LEN bits wide).
// ---------------------------------------------------------------------------
module iq_lpf_decim #(
    parameter int DATA_W   = 5,
    parameter int LOG2_LEN = 2,
    parameter int DECIM    = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic signed [DATA_W-1:0] I_BB,
    input  logic signed [DATA_W-1:0] Q_BB,
    input  logic                     demod_rdy,
    output logic signed [DATA_W-1:0] I_LP,
    output logic signed [DATA_W-1:0] Q_LP,
    output logic                     lpf_rdy
);

    localparam int LEN    = 1 << LOG2_LEN;
    localparam int SW     = DATA_W + LOG2_LEN;      // running-sum width
    localparam int RW     = SW + 1;                 // one guard bit for the rounding add
    localparam int FILL_W = LOG2_LEN + 1;           // must be able to hold LEN itself
    localparam int DC_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int HALF   = LEN / 2;

    localparam logic signed [RW-1:0]     Y_MAX_W = RW'((1 <<< (DATA_W - 1)) - 1);
    localparam logic signed [RW-1:0]     Y_MIN_W = -RW'(1 <<< (DATA_W - 1));
    localparam logic signed [DATA_W-1:0] Y_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Shared control: write pointer, fill counter, decimation counter
    // ------------------------------------------------------------------
    logic [LOG2_LEN-1:0] wp_q,   wp_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [DC_W-1:0]     dc_q,   dc_d;
    logic                rdy_q,  rdy_d;
    logic                win_ok;
    logic                emit;

    always_comb begin
        wp_d   = wp_q;
        fill_d = fill_q;
        dc_d   = dc_q;
        // The window counts the sample being accepted this cycle, so it is
        // valid once LEN-1 samples are already stored.
        win_ok = (fill_q >= FILL_W'(LEN - 1));
        emit   = demod_rdy && win_ok && (dc_q == '0);
        rdy_d  = emit;
        if (demod_rdy) begin
            wp_d   = wp_q + LOG2_LEN'(1);
            fill_d = (fill_q == FILL_W'(LEN)) ? fill_q : fill_q + FILL_W'(1);
            if (win_ok) begin
                dc_d = (dc_q == DC_W'(DECIM - 1)) ? '0 : dc_q + DC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp_q   <= '0;
            fill_q <= '0;
            dc_q   <= '0;
            rdy_q  <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            fill_q <= fill_d;
            dc_q   <= dc_d;
            rdy_q  <= rdy_d;
        end
    end

    assign lpf_rdy = rdy_q;

    // ------------------------------------------------------------------
    // Per-channel datapath: index 0 = I, index 1 = Q
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] din  [2];
    logic signed [DATA_W-1:0] dout [2];

    assign din[0] = I_BB;
    assign din[1] = Q_BB;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic signed [DATA_W-1:0] buf_q [LEN];
            logic signed [DATA_W-1:0] buf_d [LEN];
            logic signed [SW-1:0]     sum_q, sum_d;
            logic signed [SW-1:0]     sum_new;
            logic signed [RW-1:0]     rnd;
            logic signed [RW-1:0]     shifted;
            logic signed [DATA_W-1:0] y;
            logic signed [DATA_W-1:0] out_q, out_d;

            always_comb begin
                buf_d = buf_q;
                sum_d = sum_q;
                out_d = out_q;

                // Drop the oldest sample, add the newest; the sum always
                // equals the sum of the delay line, so SW bits never overflow.
                sum_new = sum_q
                        + {{LOG2_LEN{din[gi][DATA_W-1]}}, din[gi]}
                        - {{LOG2_LEN{buf_q[wp_q][DATA_W-1]}}, buf_q[wp_q]};

                // Round half up, then divide by LEN with an arithmetic shift.
                rnd     = {sum_new[SW-1], sum_new} + RW'(HALF);
                shifted = rnd >>> LOG2_LEN;

                if (shifted > Y_MAX_W) begin
                    y = Y_MAX;
                end else if (shifted < Y_MIN_W) begin
                    y = Y_MIN;
                end else begin
                    y = shifted[DATA_W-1:0];
                end

                if (demod_rdy) begin
                    buf_d[wp_q] = din[gi];
                    sum_d       = sum_new;
                end
                if (emit) begin
                    out_d = y;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int k = 0; k < LEN; k++) begin
                        buf_q[k] <= '0;
                    end
                    sum_q <= '0;
                    out_q <= '0;
                end else begin
                    buf_q <= buf_d;
                    sum_q <= sum_d;
                    out_q <= out_d;
                end
            end

            assign dout[gi] = out_q;
        end
    endgenerate

    assign I_LP = dout[0];
    assign Q_LP = dout[1];

endmodule

// File: tb/tb_iq_lpf_decim.sv
// ---------------------------------------------------------------------------
// tb_iq_lpf_decim
//
// Directed test of iq_lpf_decim with default parameters (DATA_W=5, LEN=4,
// DECIM=2). Inputs are driven on the falling edge; outputs are sampled on
// the falling edge that follows the accepting rising edge. Expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_iq_lpf_decim;

    logic              clk;
    logic              resetn;
    logic signed [4:0] I_BB;
    logic signed [4:0] Q_BB;
    logic              demod_rdy;
    logic signed [4:0] I_LP;
    logic signed [4:0] Q_LP;
    logic              lpf_rdy;

    int n_checks = 0;
    int n_pass   = 0;
    int hold_i   = 0;
    int hold_q   = 0;

    iq_lpf_decim #(
        .DATA_W  (5),
        .LOG2_LEN(2),
        .DECIM   (2)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .I_BB     (I_BB),
        .Q_BB     (Q_BB),
        .demod_rdy(demod_rdy),
        .I_LP     (I_LP),
        .Q_LP     (Q_LP),
        .lpf_rdy  (lpf_rdy)
    );

    // 50 MHz
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. Pulses resetn low asynchronously in the
    // middle of the low clock phase and confirms outputs clear immediately.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #3 resetn = 1'b0;
        #1;
        chk({tag, "_rst_rdy"}, int'(lpf_rdy), 0);
        chk({tag, "_rst_i"},   int'(I_LP),    0);
        chk({tag, "_rst_q"},   int'(Q_LP),    0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        hold_i = 0;
        hold_q = 0;
    endtask

    // Called at a falling edge. One strobe, then 'idle' quiet cycles. The
    // strobe's effect is checked at the next falling edge; idle cycles
    // check that lpf_rdy stays low and the outputs hold.
    task automatic send(input string tag, input int i, input int q, input int idle,
                        input bit exp_rdy, input int exp_i, input int exp_q);
        I_BB      = 5'(i);
        Q_BB      = 5'(q);
        demod_rdy = 1'b1;
        @(negedge clk);
        demod_rdy = 1'b0;
        chk({tag, "_rdy"}, int'(lpf_rdy), int'(exp_rdy));
        if (exp_rdy) begin
            hold_i = exp_i;
            hold_q = exp_q;
        end
        chk({tag, "_i"}, int'(I_LP), hold_i);
        chk({tag, "_q"}, int'(Q_LP), hold_q);
        $display("strobe %s: in I=%0d Q=%0d -> lpf_rdy=%0d I_LP=%0d Q_LP=%0d",
                 tag, i, q, lpf_rdy, I_LP, Q_LP);
        for (int k = 0; k < idle; k++) begin
            @(negedge clk);
            chk({tag, "_idle_rdy"}, int'(lpf_rdy), 0);
            chk({tag, "_idle_i"},   int'(I_LP),    hold_i);
        end
    endtask

    initial begin
        int step_in [8];
        int step_ex [8];
        int c_i [4];
        int c_q [4];

        resetn    = 1'b0;
        demod_rdy = 1'b0;
        I_BB      = '0;
        Q_BB      = '0;

        // Reset held 100 ns while strobes arrive: nothing may come out.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            I_BB      = 5'sd15;
            Q_BB      = 5'sd15;
            demod_rdy = (k % 2 == 0);
            chk("rst_hold_rdy", int'(lpf_rdy), 0);
            chk("rst_hold_i",   int'(I_LP),    0);
            chk("rst_hold_q",   int'(Q_LP),    0);
        end
        @(negedge clk);
        demod_rdy = 1'b0;
        resetn    = 1'b1;

        // Constant input, strobe every 5th clock: outputs after 4, 6, 8.
        for (int k = 1; k <= 8; k++) begin
            send($sformatf("const%0d", k), 8, -4, 4, (k >= 4) && (k % 2 == 0), 8, -4);
        end

        // Step on I: 0,0,0,0,12,12,12,12 -> 0 @4, 6 @6, 12 @8.
        do_reset("step");
        step_in = '{0, 0, 0, 0, 12, 12, 12, 12};
        step_ex = '{0, 0, 0, 0, 0, 6, 0, 12};
        for (int k = 0; k < 8; k++) begin
            send($sformatf("step%0d", k + 1), step_in[k], 0, 1,
                 (k >= 3) && (k % 2 == 1), step_ex[k], 0);
        end

        // Rounding: I 1,1,1,0 / Q -1,-1,-1,0 -> 1 / -1.
        do_reset("rnd3");
        c_i = '{1, 1, 1, 0};
        c_q = '{-1, -1, -1, 0};
        for (int k = 0; k < 4; k++) begin
            send($sformatf("rnd3_%0d", k + 1), c_i[k], c_q[k], 1, k == 3, 1, -1);
        end

        // Rounding: I 1,1,0,0 / Q -1,-1,0,0 -> 1 / 0 (halves round up).
        do_reset("rnd2");
        c_i = '{1, 1, 0, 0};
        c_q = '{-1, -1, 0, 0};
        for (int k = 0; k < 4; k++) begin
            send($sformatf("rnd2_%0d", k + 1), c_i[k], c_q[k], 1, k == 3, 1, 0);
        end

        // Extremes: I=15, Q=-16 all taps.
        do_reset("ext");
        for (int k = 0; k < 4; k++) begin
            send($sformatf("ext_%0d", k + 1), 15, -16, 1, k == 3, 15, -16);
        end

        // Alternating 15/-16: sum -2 -> 0 on both channels. The reset also
        // checks that the held 15/-16 clear asynchronously.
        do_reset("alt");
        c_i = '{15, -16, 15, -16};
        c_q = '{-16, 15, -16, 15};
        for (int k = 0; k < 4; k++) begin
            send($sformatf("alt_%0d", k + 1), c_i[k], c_q[k], 1, k == 3, 0, 0);
        end

        // Mid-operation reset: three 15s are discarded.
        do_reset("mid_pre");
        for (int k = 0; k < 3; k++) begin
            send($sformatf("mid15_%0d", k + 1), 15, 15, 1, 1'b0, 0, 0);
        end
        do_reset("mid");

        // Back-to-back strobes of 4: first output only after the 4th, value 4,
        // then lpf_rdy on alternate cycles.
        I_BB      = 5'sd4;
        Q_BB      = 5'sd4;
        demod_rdy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) demod_rdy = 1'b0;
            chk($sformatf("b2b%0d_rdy", k), int'(lpf_rdy), int'((k >= 4) && (k % 2 == 0)));
            chk($sformatf("b2b%0d_i", k), int'(I_LP), (k >= 4) ? 4 : 0);
            chk($sformatf("b2b%0d_q", k), int'(Q_LP), (k >= 4) ? 4 : 0);
            $display("b2b strobe %0d: lpf_rdy=%0d I_LP=%0d Q_LP=%0d", k, lpf_rdy, I_LP, Q_LP);
        end
        @(negedge clk);
        chk("b2b_tail_rdy", int'(lpf_rdy), 0);
        chk("b2b_tail_i",   int'(I_LP),    4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
